// File: rtl/matrix_inv_2x2_seq.sv
// matrix_inv_2x2_seq
//   Sequential 2x2 signed fixed-point matrix inverter, Res = adj(A) / det(A).
//   Each element of the adjugate is divided by the determinant with a
//   radix-2 restoring divider, one quotient bit per enabled clock. The
//   results are sign-corrected and saturated to WIDTH bits.
//
// Parameters
//   WIDTH  element width, two's complement, Q(WIDTH-FRAC).FRAC
//   FRAC   fractional bits of A and Res (1 <= FRAC < WIDTH-1)
//
// Ports
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset (aborts a running inversion)
//   clk_en    clock enable; nothing advances while low
//   start     request an inversion; accepted only when idle
//   A         input matrix, captured when start is accepted
//   Res       inverse in the same Q format; held between runs
//   busy      high from the cycle after start is accepted until done
//   done      one enabled-cycle pulse when Res/sat/singular are valid
//   singular  det(A) == 0 for the last result
//   sat       bit 2*i+j set when Res[i][j] was clamped
module matrix_inv_2x2_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] A   [0:1][0:1],
    output logic signed [WIDTH-1:0] Res [0:1][0:1],
    output logic                    busy,
    output logic                    done,
    output logic                    singular,
    output logic [3:0]              sat
);

    localparam int N  = WIDTH + 2*FRAC;   // quotient bits / divide iterations
    localparam int DW = 2*WIDTH + 1;      // determinant width
    localparam int RW = 2*WIDTH + 2;      // divider remainder width
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] ITER_LAST = CW'(N - 1);

    localparam logic [N-1:0] POS_MAX = {{(N-WIDTH){1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [N-1:0] NEG_MAG = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_DET, S_DIV, S_STORE, S_DONE} state_t;

    state_t                  state;
    logic [1:0]              idx;
    logic [CW-1:0]           iter;

    logic signed [WIDTH-1:0] a_p0 [0:1][0:1];
    logic signed [DW-1:0]    det_p1;
    logic [N-1:0]            num_sr;
    logic [RW-1:0]           rem;
    logic [N-1:0]            quo;

    // Adjugate element k (row-major) at WIDTH+1 bits so -(-2**(WIDTH-1)) does not wrap.
    function automatic logic signed [WIDTH:0] adj_of(input logic [1:0] k);
        logic signed [WIDTH:0] v;
        case (k)
            2'd0:    v =  (WIDTH+1)'(a_p0[1][1]);
            2'd1:    v = -(WIDTH+1)'(a_p0[0][1]);
            2'd2:    v = -(WIDTH+1)'(a_p0[1][0]);
            default: v =  (WIDTH+1)'(a_p0[0][0]);
        endcase
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH:0] v);
        return WIDTH'(v[WIDTH] ? -v : v);
    endfunction

    // Apply the sign to the quotient magnitude and clamp; returns {sat, value}.
    function automatic logic [WIDTH:0] sign_sat(input logic neg, input logic [N-1:0] q);
        logic [WIDTH-1:0] m;
        m = q[WIDTH-1:0];
        if (neg) begin
            if (q > NEG_MAG) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
            return {1'b0, -m};
        end
        if (q > POS_MAX) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        return {1'b0, m};
    endfunction

    logic signed [DW-1:0]    det_c;
    logic [1:0]              nxt_idx;
    logic [N-1:0]            num_load;
    logic signed [WIDTH:0]   adj_cur;
    logic [DW-1:0]           den;
    logic [RW-1:0]           den_ext;
    logic [RW-1:0]           rem_sh;
    logic                    rem_ge;
    logic [WIDTH:0]          st_val;

    always_comb begin
        det_c    = DW'(a_p0[0][0]) * DW'(a_p0[1][1]) - DW'(a_p0[0][1]) * DW'(a_p0[1][0]);
        nxt_idx  = (state == S_DET) ? 2'd0 : idx + 2'd1;
        num_load = {mag_of(adj_of(nxt_idx)), {(2*FRAC){1'b0}}};
        adj_cur  = adj_of(idx);
        den      = det_p1[DW-1] ? DW'(-det_p1) : DW'(det_p1);
        den_ext  = {1'b0, den};
        rem_sh   = (rem << 1) | RW'(num_sr[N-1]);
        rem_ge   = (rem_sh >= den_ext);
        st_val   = sign_sat(adj_cur[WIDTH] ^ det_p1[DW-1], quo);
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
            sat      <= 4'b0;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    Res[i][j] <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sat      <= 4'b0;
                        singular <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_DET;
                    end
                end
                S_DET: begin
                    idx   <= 2'd0;
                    iter  <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    // The zero test needs the registered determinant, so it
                    // resolves on the first divide cycle before any result is written.
                    if (det_p1 == '0) begin
                        singular <= 1'b1;
                        sat      <= 4'b0;
                        for (int i = 0; i < 2; i++)
                            for (int j = 0; j < 2; j++)
                                Res[i][j] <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else if (iter == ITER_LAST) begin
                        state <= S_STORE;
                    end else begin
                        iter <= iter + CW'(1);
                    end
                end
                S_STORE: begin
                    Res[idx[1]][idx[0]] <= $signed(st_val[WIDTH-1:0]);
                    sat[idx]            <= st_val[WIDTH];
                    iter                <= '0;
                    if (idx == 2'd3) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_DIV;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, determinant, restoring divider
    always_ff @(posedge clk) begin
        if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (start) a_p0 <= A;
                end
                S_DET, S_STORE: begin
                    if (state == S_DET) det_p1 <= det_c;
                    num_sr <= num_load;
                    rem    <= '0;
                    quo    <= '0;
                end
                S_DIV: begin
                    num_sr <= num_sr << 1;
                    rem    <= rem_ge ? rem_sh - den_ext : rem_sh;
                    quo    <= {quo[N-2:0], rem_ge};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_inv_2x2_seq.sv
module tb_matrix_inv_2x2_seq;

    localparam int W   = 16;
    localparam int F   = 6;
    localparam int LAT = 117;

    logic                clk = 1'b0;
    logic                rst;
    logic                clk_en;
    logic                start;
    logic signed [W-1:0] A   [0:1][0:1];
    logic signed [W-1:0] Res [0:1][0:1];
    logic                busy;
    logic                done;
    logic                singular;
    logic [3:0]          sat;

    int checks   = 0;
    int failures = 0;

    matrix_inv_2x2_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .start    (start),
        .A        (A),
        .Res      (Res),
        .busy     (busy),
        .done     (done),
        .singular (singular),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    // Reference: exact rational inverse, truncated toward zero, then clamped.
    function automatic void model(input int a[4], output int r[4], output logic [3:0] s,
                                  output logic sg);
        longint det, q;
        longint adj[4];
        det = longint'(a[0]) * a[3] - longint'(a[1]) * a[2];
        adj[0] = a[3]; adj[1] = -a[1]; adj[2] = -a[2]; adj[3] = a[0];
        s  = 4'b0;
        sg = (det == 0);
        for (int k = 0; k < 4; k++) begin
            if (det == 0) begin
                r[k] = 0;
            end else begin
                q = (adj[k] * (longint'(1) << (2*F))) / det;
                if (q > 32767)       begin r[k] = 32767;  s[k] = 1'b1; end
                else if (q < -32768) begin r[k] = -32768; s[k] = 1'b1; end
                else                 r[k] = int'(q);
            end
        end
    endfunction

    function automatic int res_at(input int k);
        return int'(Res[k/2][k%2]);
    endfunction

    task automatic set_a(input int a[4]);
        for (int k = 0; k < 4; k++) A[k/2][k%2] = W'(a[k]);
    endtask

    // Runs one inversion from an idle DUT; called at a point 1 time unit after a posedge.
    task automatic do_run(input int a[4], input int en_pct, input int ghost_at,
                          output int lat, output bit timeout, output bit pulse_ok,
                          output bit busy_ok);
        int cnt;
        int g[4];
        set_a(a);
        start  = 1'b1;
        clk_en = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cnt     = 0;
        timeout = 1'b1;
        busy_ok = (busy === 1'b1);
        for (int c = 0; c < 3000; c++) begin
            clk_en = ($urandom_range(99) < en_pct);
            if (cnt == ghost_at && clk_en) begin
                for (int k = 0; k < 4; k++) g[k] = int'($urandom_range(200)) - 100;
                set_a(g);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (clk_en) cnt++;
            if (done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        lat   = cnt;
        pulse_ok = (busy === 1'b0);
        for (int c = 0; c < 50; c++) begin
            clk_en = ($urandom_range(99) < en_pct);
            @(posedge clk); #1;
            if (clk_en) begin
                if (done !== 1'b0) pulse_ok = 1'b0;
                break;
            end else if (done !== 1'b1) begin
                pulse_ok = 1'b0;
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clk_en = 1'b0; start = 1'b0;
        for (int k = 0; k < 4; k++) A[k/2][k%2] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (singular !== 1'b0) begin failures++; $display("FAIL reset_singular got=%b exp=0", singular); end
        checks++; if (sat !== 4'b0)      begin failures++; $display("FAIL reset_sat got=%b exp=0000", sat); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_at(k) !== 0) begin failures++; $display("FAIL reset_res%0d got=%0d exp=0", k, res_at(k)); end
        end
        rst = 1'b0;
        clk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int va[4][4] = '{'{128, 0, 0, 256}, '{64, 128, 192, 256}, '{1, 2000, 0, 1}, '{64, 128, 32, 64}};
        int vr[4][4] = '{'{32, 0, 0, 16}, '{-128, 64, 96, -32}, '{4096, -32768, 0, 4096}, '{0, 0, 0, 0}};
        logic [3:0] vs[4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
        logic vg[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int vl[4] = '{LAT, LAT, LAT, 2};
        int lat; bit to, pok, bok;
        for (int t = 0; t < 4; t++) begin
            do_run(va[t], 100, -1, lat, to, pok, bok);
            checks++; if (to) begin failures++; $display("FAIL dir%0d_timeout got=no_done exp=done", t); end
            checks++; if (lat != vl[t]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, lat, vl[t]); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (res_at(k) !== vr[t][k]) begin
                    failures++; $display("FAIL dir%0d_res%0d got=%0d exp=%0d", t, k, res_at(k), vr[t][k]);
                end
            end
            checks++; if (sat !== vs[t]) begin failures++; $display("FAIL dir%0d_sat got=%b exp=%b", t, sat, vs[t]); end
            checks++; if (singular !== vg[t]) begin failures++; $display("FAIL dir%0d_singular got=%b exp=%b", t, singular, vg[t]); end
            checks++; if (!pok) begin failures++; $display("FAIL dir%0d_done_pulse got=bad exp=one_cycle", t); end
            checks++; if (!bok) begin failures++; $display("FAIL dir%0d_busy got=low exp=high", t); end
        end
    endtask

    task automatic test_clk_en;
        int a[4] = '{64, 128, 192, 256};
        int er[4]; logic [3:0] es; logic eg;
        int lat; bit to, pok, bok;
        model(a, er, es, eg);
        for (int rep = 0; rep < 2; rep++) begin
            do_run(a, 50, -1, lat, to, pok, bok);
            checks++; if (to || lat != LAT) begin failures++; $display("FAIL clken_latency got=%0d exp=%0d", lat, LAT); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (res_at(k) !== er[k]) begin failures++; $display("FAIL clken_res%0d got=%0d exp=%0d", k, res_at(k), er[k]); end
            end
            checks++; if (!pok) begin failures++; $display("FAIL clken_done_pulse got=bad exp=one_enabled_cycle"); end
            checks++; if (!bok) begin failures++; $display("FAIL clken_busy got=low exp=high"); end
        end
    endtask

    task automatic test_reset_mid;
        int a[4] = '{64, 128, 192, 256};
        int b[4] = '{128, 0, 0, 256};
        int er[4]; logic [3:0] es; logic eg;
        int lat; bit to, pok, bok, seen;
        set_a(a);
        start = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // edge 70 falls inside the third element's divide
        repeat (70) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0 || singular !== 1'b0 || sat !== 4'b0) begin
            failures++; $display("FAIL rstmid_flags got=%b%b%b exp=000", done, singular, |sat);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_at(k) !== 0) begin failures++; $display("FAIL rstmid_res%0d got=%0d exp=0", k, res_at(k)); end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rstmid_no_done got=done exp=none"); end
        model(b, er, es, eg);
        do_run(b, 100, -1, lat, to, pok, bok);
        checks++; if (to || lat != LAT) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=%0d", lat, LAT); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_at(k) !== er[k]) begin failures++; $display("FAIL rstmid_fresh_res%0d got=%0d exp=%0d", k, res_at(k), er[k]); end
        end
    endtask

    task automatic test_random;
        int a[4]; int er[4]; logic [3:0] es; logic eg;
        int lat; bit to, pok, bok;
        int x, y;
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 5) begin
                x = int'($urandom_range(400)) - 200;
                y = int'($urandom_range(400)) - 200;
                a = '{x, y, 3*x, 3*y};
            end else if (t % 2 == 0) begin
                for (int k = 0; k < 4; k++) a[k] = int'($urandom_range(600)) - 300;
            end else begin
                for (int k = 0; k < 4; k++) a[k] = int'($urandom_range(65535)) - 32768;
            end
            model(a, er, es, eg);
            do_run(a, (t % 3 == 0) ? 60 : 100, -1, lat, to, pok, bok);
            checks++;
            if (to || lat != (eg ? 2 : LAT)) begin
                failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, eg ? 2 : LAT);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (res_at(k) !== er[k]) begin
                    failures++;
                    $display("FAIL rand%0d_res%0d got=%0d exp=%0d A=%0d,%0d,%0d,%0d", t, k, res_at(k), er[k],
                             a[0], a[1], a[2], a[3]);
                end
            end
            checks++; if (sat !== es) begin failures++; $display("FAIL rand%0d_sat got=%b exp=%b", t, sat, es); end
            checks++; if (singular !== eg) begin failures++; $display("FAIL rand%0d_singular got=%b exp=%b", t, singular, eg); end
        end
    endtask

    task automatic test_back_to_back;
        int a[4] = '{64, 128, 192, 256};
        int b[4] = '{1, 2000, 0, 1};
        int er[4]; logic [3:0] es; logic eg;
        int lat; bit to, pok, bok;
        model(a, er, es, eg);
        do_run(a, 100, 40, lat, to, pok, bok);
        checks++; if (to || lat != LAT) begin failures++; $display("FAIL b2b_ghost_latency got=%0d exp=%0d", lat, LAT); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_at(k) !== er[k]) begin failures++; $display("FAIL b2b_ghost_res%0d got=%0d exp=%0d", k, res_at(k), er[k]); end
        end
        model(b, er, es, eg);
        do_run(b, 100, -1, lat, to, pok, bok);
        checks++; if (to || lat != LAT) begin failures++; $display("FAIL b2b_next_latency got=%0d exp=%0d", lat, LAT); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_at(k) !== er[k]) begin failures++; $display("FAIL b2b_next_res%0d got=%0d exp=%0d", k, res_at(k), er[k]); end
        end
        checks++; if (sat !== es) begin failures++; $display("FAIL b2b_next_sat got=%b exp=%b", sat, es); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clk_en();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
